// File: rtl/xor_checksum_if.sv
// Handshake bundle for xor_checksum: producer-side beat channel and
// consumer-side result channel. The block itself connects through the slave
// modport. The environment that feeds it and drains it uses master.
interface xor_checksum_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_parity;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_parity, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_parity, out_count, out_ovf
   );
endinterface

// File: rtl/xor_checksum.sv
// Streaming XOR checksum. It folds every accepted beat of a frame into a
// seeded accumulator and presents sum, parity and a saturating beat count
// one cycle after the last beat. The result is held until the consumer
// takes it. There is no bypass: the next frame starts the cycle after the
// result handshake.
module xor_checksum #(
   parameter int               WIDTH = 16,
   parameter int               CNT_W = 8,
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input logic           clk,
   input logic           reset,
   xor_checksum_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             valid_r;
   logic [WIDTH-1:0] sum_r;
   logic             parity_r;
   logic [CNT_W-1:0] count_r;
   logic             ovf_r;

   logic             in_ready_w;
   logic             accept;
   logic             done;
   logic [WIDTH-1:0] acc_base;
   logic [CNT_W-1:0] cnt_base;
   logic             ovf_base;
   logic [WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;

   // in_ready decodes the state register only, so in_valid and out_ready
   // have no combinational path to it.
   assign in_ready_w = (state != HOLD);
   assign accept     = bus.in_valid & in_ready_w;
   assign done       = accept & bus.in_last;

   // Post-update accumulator values. In IDLE the fold restarts from the seed,
   // so the first beat needs no separate clear cycle.
   always_comb begin
      acc_base = (state == IDLE) ? SEED : acc;
      cnt_base = (state == IDLE) ? '0 : cnt;
      ovf_base = (state == IDLE) ? 1'b0 : ovf;
      acc_nxt  = acc_base ^ bus.in_data;
      cnt_nxt  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_W'(1);
      ovf_nxt  = ovf_base | (cnt_base == CNT_MAX);
   end

   // Frame sequencing: IDLE -> ACCUM on the first beat, -> HOLD on the last
   // beat, and back to IDLE when the result is taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) state <= bus.in_last ? HOLD : ACCUM;
            end
            HOLD: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Running checksum and beat count. Both are updated only on an accepted
   // beat, so data presented while in_valid is low never reaches them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= SEED;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end else if (state == HOLD && bus.out_ready) begin
         acc <= SEED;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

   // Result registers: captured on the last beat's edge and held until the
   // result handshake. The values themselves are left in place after the
   // handshake, because only out_valid is cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r  <= 1'b0;
         sum_r    <= '0;
         parity_r <= 1'b0;
         count_r  <= '0;
         ovf_r    <= 1'b0;
      end else if (done) begin
         valid_r  <= 1'b1;
         sum_r    <= acc_nxt;
         parity_r <= ^acc_nxt;
         count_r  <= cnt_nxt;
         ovf_r    <= ovf_nxt;
      end else if (valid_r && bus.out_ready) begin
         valid_r  <= 1'b0;
      end
   end

   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = valid_r;
   assign bus.out_sum    = sum_r;
   assign bus.out_parity = parity_r;
   assign bus.out_count  = count_r;
   assign bus.out_ovf    = ovf_r;

endmodule
